// File: rtl/bananachine_pkg.sv
// -----------------------------------------------------------------------------
// bananachine_pkg
// Shared definitions for the Bananachine control path: the controller state
// encoding, instruction opcode / extended-opcode values, the ALU add code,
// branch condition codes and PSR flag bit positions.
// Ports: none (package).
// -----------------------------------------------------------------------------
package bananachine_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    IR_LOAD = 4'd1,
    DECODE  = 4'd2,
    EX_ALU  = 4'd3,
    LD_ADDR = 4'd4,
    LD_WB   = 4'd5,
    ST      = 4'd6,
    BRANCH  = 4'd7,
    JCOND   = 4'd8,
    JAL     = 4'd9,
    NOP_END = 4'd10
  } state_t;

  // Primary opcodes (instruction bits 15-12)
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_CMP     = 4'b1011;

  // Extended opcodes under OP_SPECIAL (instruction bits 7-4)
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [5:0] ALU_ADD = 6'b000101;

  // Condition codes carried in A_index
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_UC = 4'b1110;

  // PSR flag bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

  // Immediate-form ALU opcodes: the opcode itself is the ALU operation.
  function automatic logic is_iform(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b1001, 4'b1011, 4'b1101: is_iform = 1'b1;
      default:                   is_iform = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Combinational branch/jump condition evaluator shared by BRANCH and JCOND.
// Ports:
//   A_index   in  [REG_BITS-1:0] condition code (instruction bits 11-8)
//   psr_flags in  [WIDTH-1:0]    processor status flags
//   taken     out                condition satisfied
// -----------------------------------------------------------------------------
module cond_eval
  import bananachine_pkg::*;
#(
  parameter int REG_BITS = 4,
  parameter int WIDTH    = 16
) (
  input  logic [REG_BITS-1:0] A_index,
  input  logic [WIDTH-1:0]    psr_flags,
  output logic                taken
);

  // Only five flag bits matter; the rest are deliberately ignored.
  logic w_unused_flags;
  assign w_unused_flags = ^psr_flags;

  always_comb begin
    taken = 1'b0;
    case (A_index)
      CC_EQ:   taken =  psr_flags[FLAG_Z];
      CC_NE:   taken = ~psr_flags[FLAG_Z];
      CC_CS:   taken =  psr_flags[FLAG_C];
      CC_CC:   taken = ~psr_flags[FLAG_C];
      CC_HI:   taken =  psr_flags[FLAG_L];
      CC_LS:   taken = ~psr_flags[FLAG_L];
      CC_GT:   taken =  psr_flags[FLAG_N];
      CC_LE:   taken = ~psr_flags[FLAG_N];
      CC_FS:   taken =  psr_flags[FLAG_F];
      CC_FC:   taken = ~psr_flags[FLAG_F];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multicycle controller for the Bananachine datapath: fetches, decodes and
// sequences each instruction, driving every datapath control and the memory
// write strobe. Outputs are a Moore decode of the state, except pc_src in
// BRANCH/JCOND (uses psr_flags) and alu_cont/alu_B_src in EX_ALU (use opcodes).
// Ports:
//   clk, reset (async, active-low)
//   op_code, ext_op_code, A_index, psr_flags  in   instruction fields / flags
//   reg_write, alu_A_src, alu_B_src, pc_en,
//   loading, storing, instruction_en          out  datapath controls
//   mem_write                                 out  memory write enable
//   pc_src        out [1:0] 0=ALU 1=reg_B 2=PC+1
//   reg_write_src out [1:0] 0=ALU 1=memory 2=PC+1
//   alu_cont      out [ALU_CONT_BITS-1:0] ALU operation
// -----------------------------------------------------------------------------
module control_fsm
  import bananachine_pkg::*;
#(
  parameter int ALU_CONT_BITS    = 6,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int REG_BITS         = 4,
  parameter int WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [REG_BITS-1:0]         A_index,
  input  logic [WIDTH-1:0]            psr_flags,
  output logic                        reg_write,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic                        pc_en,
  output logic                        loading,
  output logic                        storing,
  output logic                        instruction_en,
  output logic                        mem_write,
  output logic [1:0]                  pc_src,
  output logic [1:0]                  reg_write_src,
  output logic [ALU_CONT_BITS-1:0]    alu_cont
);

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_REGB = 2'd1;
  localparam logic [1:0] PC_SRC_INC  = 2'd2;

  localparam logic [1:0] RW_SRC_ALU = 2'd0;
  localparam logic [1:0] RW_SRC_MEM = 2'd1;
  localparam logic [1:0] RW_SRC_PC1 = 2'd2;

  state_t r_state;
  state_t w_next_state;
  logic   w_taken;
  logic   w_rform;

  cond_eval #(
    .REG_BITS (REG_BITS),
    .WIDTH    (WIDTH)
  ) u_cond_eval (
    .A_index   (A_index),
    .psr_flags (psr_flags),
    .taken     (w_taken)
  );

  assign w_rform = (op_code == OP_RTYPE);

  // State register. Reset drops straight to FETCH, so an aborted instruction
  // can never leave a write strobe asserted.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  // NOTE: every combinational output is given a default up front so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = FETCH;
    case (r_state)
      FETCH:   w_next_state = IR_LOAD;
      IR_LOAD: w_next_state = DECODE;
      DECODE: begin
        if (op_code == OP_RTYPE) begin
          w_next_state = EX_ALU;
        end else if (op_code == OP_SPECIAL) begin
          case (ext_op_code)
            EXT_LOAD:  w_next_state = LD_ADDR;
            EXT_STOR:  w_next_state = ST;
            EXT_JAL:   w_next_state = JAL;
            EXT_JCOND: w_next_state = JCOND;
            default:   w_next_state = NOP_END;
          endcase
        end else if (op_code == OP_BCOND) begin
          w_next_state = BRANCH;
        end else if (is_iform(op_code)) begin
          w_next_state = EX_ALU;
        end else begin
          w_next_state = NOP_END;
        end
      end
      LD_ADDR: w_next_state = LD_WB;
      default: w_next_state = FETCH;  // all terminal states
    endcase
  end

  // Output decode
  always_comb begin
    reg_write      = 1'b0;
    alu_A_src      = 1'b1;
    alu_B_src      = 1'b0;
    pc_en          = 1'b0;
    loading        = 1'b0;
    storing        = 1'b0;
    instruction_en = 1'b0;
    mem_write      = 1'b0;
    pc_src         = PC_SRC_INC;
    reg_write_src  = RW_SRC_ALU;
    alu_cont       = ALU_CONT_BITS'(ALU_ADD);

    case (r_state)
      IR_LOAD: instruction_en = 1'b1;
      EX_ALU: begin
        pc_en = 1'b1;
        if (w_rform) begin
          alu_B_src = 1'b0;
          alu_cont  = ALU_CONT_BITS'(ext_op_code);
          // CMP only updates flags; the R-form encoding reuses the opcode value
          reg_write = (ext_op_code != OP_CMP);
        end else begin
          alu_B_src = 1'b1;
          alu_cont  = ALU_CONT_BITS'(op_code);
          reg_write = (op_code != OP_CMP);
        end
      end
      LD_ADDR: loading = 1'b1;
      LD_WB: begin
        loading       = 1'b1;
        reg_write     = 1'b1;
        reg_write_src = RW_SRC_MEM;
        pc_en         = 1'b1;
      end
      ST: begin
        storing   = 1'b1;
        mem_write = 1'b1;
        pc_en     = 1'b1;
      end
      BRANCH: begin
        // PC-relative target: PC + immediate through the ALU
        alu_A_src = 1'b0;
        alu_B_src = 1'b1;
        alu_cont  = ALU_CONT_BITS'(ALU_ADD);
        pc_en     = 1'b1;
        pc_src    = w_taken ? PC_SRC_ALU : PC_SRC_INC;
      end
      JCOND: begin
        pc_en  = 1'b1;
        pc_src = w_taken ? PC_SRC_REGB : PC_SRC_INC;
      end
      JAL: begin
        reg_write     = 1'b1;
        reg_write_src = RW_SRC_PC1;
        pc_en         = 1'b1;
        pc_src        = PC_SRC_REGB;
      end
      NOP_END: begin
        pc_en  = 1'b1;
        pc_src = PC_SRC_INC;
      end
      default: ;  // FETCH, DECODE: defaults only
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
// Directed bench for control_fsm. For each instruction the expected per-cycle
// control vector is computed by a reference model and queued; each cycle the
// oldest entry is popped and compared against the DUT outputs mid-cycle.
// -----------------------------------------------------------------------------
module tb_control_fsm;

  logic        clk;
  logic        reset;
  logic [3:0]  op_code;
  logic [3:0]  ext_op_code;
  logic [3:0]  A_index;
  logic [15:0] psr_flags;
  logic        reg_write, alu_A_src, alu_B_src, pc_en;
  logic        loading, storing, instruction_en, mem_write;
  logic [1:0]  pc_src, reg_write_src;
  logic [5:0]  alu_cont;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [17:0] vec;
  } exp_t;

  exp_t sb_q[$];

  control_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .op_code        (op_code),
    .ext_op_code    (ext_op_code),
    .A_index        (A_index),
    .psr_flags      (psr_flags),
    .reg_write      (reg_write),
    .alu_A_src      (alu_A_src),
    .alu_B_src      (alu_B_src),
    .pc_en          (pc_en),
    .loading        (loading),
    .storing        (storing),
    .instruction_en (instruction_en),
    .mem_write      (mem_write),
    .pc_src         (pc_src),
    .reg_write_src  (reg_write_src),
    .alu_cont       (alu_cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // {reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
  //  instruction_en, mem_write, pc_src, reg_write_src, alu_cont}
  function automatic logic [17:0] obs_vec();
    return {reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
            instruction_en, mem_write, pc_src, reg_write_src, alu_cont};
  endfunction

  function automatic logic ref_taken(input logic [3:0] cc, input logic [15:0] f);
    case (cc)
      4'd0:  return f[6];
      4'd1:  return !f[6];
      4'd2:  return f[0];
      4'd3:  return !f[0];
      4'd4:  return f[2];
      4'd5:  return !f[2];
      4'd6:  return f[7];
      4'd7:  return !f[7];
      4'd8:  return f[5];
      4'd9:  return !f[5];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_iform(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011) ||
           (op == 4'b0101) || (op == 4'b1001) || (op == 4'b1011) ||
           (op == 4'b1101);
  endfunction

  // Expected controls for cycle cyc (1 = FETCH) of an instruction.
  function automatic logic [17:0] ref_vec(input int cyc, input logic [3:0] op,
                                          input logic [3:0] ext, input logic [3:0] cc,
                                          input logic [15:0] f);
    logic rw, aa, ab, pe, ld, st, ie, mw;
    logic [1:0] ps, rs;
    logic [5:0] ac;
    rw = 0; aa = 1; ab = 0; pe = 0; ld = 0; st = 0; ie = 0; mw = 0;
    ps = 2'd2; rs = 2'd0; ac = 6'b000101;
    if (cyc == 2) begin
      ie = 1;
    end else if (cyc >= 4) begin
      if (op == 4'b0000) begin
        rw = (ext != 4'b1011); pe = 1; ab = 0; ac = {2'b00, ext};
      end else if (ref_iform(op)) begin
        rw = (op != 4'b1011); pe = 1; ab = 1; ac = {2'b00, op};
      end else if (op == 4'b0100) begin
        case (ext)
          4'b0000: begin
            ld = 1;
            if (cyc == 5) begin rw = 1; rs = 2'd1; pe = 1; end
          end
          4'b0100: begin st = 1; mw = 1; pe = 1; end
          4'b1000: begin rw = 1; rs = 2'd2; pe = 1; ps = 2'd1; end
          4'b1100: begin pe = 1; ps = ref_taken(cc, f) ? 2'd1 : 2'd2; end
          default: pe = 1;
        endcase
      end else if (op == 4'b1100) begin
        aa = 0; ab = 1; pe = 1; ps = ref_taken(cc, f) ? 2'd0 : 2'd2;
      end else begin
        pe = 1;
      end
    end
    return {rw, aa, ab, pe, ld, st, ie, mw, ps, rs, ac};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Runs cycles first..last of one instruction. Entered at a negedge in the
  // cycle 'first'; returns at the negedge of cycle last+1.
  task automatic run_cycles(input logic [3:0] op, input logic [3:0] ext,
                            input logic [3:0] cc, input logic [15:0] f,
                            input int first, input int last);
    exp_t e;
    op_code = op; ext_op_code = ext; A_index = cc; psr_flags = f;
    for (int c = first; c <= last; c++) begin
      e.tag = $sformatf("op%h_ext%h_cc%h_f%h_c%0d", op, ext, cc, f, c);
      e.vec = ref_vec(c, op, ext, cc, f);
      sb_q.push_back(e);
    end
    for (int c = first; c <= last; c++) begin
      #1;
      e = sb_q.pop_front();
      check(e.tag, obs_vec(), e.vec);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                           input logic [3:0] cc, input logic [15:0] f);
    int n;
    n = (op == 4'b0100 && ext == 4'b0000) ? 5 : 4;
    run_cycles(op, ext, cc, f, 1, n);
  endtask

  localparam logic [17:0] DEFAULTS = 18'b0100_0000_10_00_000101;

  initial begin
    reset = 1'b0;
    op_code = 4'b0; ext_op_code = 4'b0; A_index = 4'b0; psr_flags = 16'h0;
    repeat (2) @(negedge clk);
    #1 check("reset_defaults", obs_vec(), DEFAULTS);
    @(negedge clk);
    reset = 1'b1;

    // ALU: R-form ADD, I-form, CMP in both forms
    run_instr(4'b0000, 4'b0101, 4'h0, 16'h0000);
    run_instr(4'b0001, 4'b0011, 4'h0, 16'h0000);
    run_instr(4'b1101, 4'b0000, 4'h3, 16'h00ff);
    run_instr(4'b0000, 4'b1011, 4'h0, 16'h0000);
    run_instr(4'b1011, 4'b0000, 4'h0, 16'h0000);
    // load / store
    run_instr(4'b0100, 4'b0000, 4'h2, 16'h0000);
    run_instr(4'b0100, 4'b0100, 4'h2, 16'h0000);
    // branches
    run_instr(4'b1100, 4'b0000, 4'h0, 16'h0040);
    run_instr(4'b1100, 4'b0000, 4'h0, 16'h0000);
    run_instr(4'b1100, 4'b0000, 4'hf, 16'hffff);
    run_instr(4'b1100, 4'b0000, 4'h1, 16'h0000);
    run_instr(4'b1100, 4'b0000, 4'h6, 16'h0080);
    run_instr(4'b1100, 4'b0000, 4'hd, 16'h00e5);
    run_instr(4'b1100, 4'b0000, 4'he, 16'h0000);
    // conditional jumps
    run_instr(4'b0100, 4'b1100, 4'h2, 16'h0001);
    run_instr(4'b0100, 4'b1100, 4'h7, 16'h0080);
    run_instr(4'b0100, 4'b1100, 4'h4, 16'h0004);
    run_instr(4'b0100, 4'b1100, 4'h9, 16'h0020);
    // JAL and undefined encodings
    run_instr(4'b0100, 4'b1000, 4'h0, 16'h0000);
    run_instr(4'b1111, 4'b0000, 4'h0, 16'h0000);
    run_instr(4'b0100, 4'b0001, 4'h0, 16'h0000);

    // Reset in the middle of EX_ALU
    run_cycles(4'b0000, 4'b0101, 4'h0, 16'h0000, 1, 3);
    #1 check("mid_ex_alu_reg_write", {17'b0, reg_write}, 18'd1);
    reset = 1'b0;
    #1 check("abort_defaults", obs_vec(), DEFAULTS);
    @(negedge clk);
    #1 check("held_reset_defaults", obs_vec(), DEFAULTS);
    @(negedge clk);
    reset = 1'b1;
    run_instr(4'b0000, 4'b0101, 4'h0, 16'h0000);
    run_instr(4'b0100, 4'b0100, 4'h0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
